// File: rtl/multisim_rw_arbiter.sv
// multisim_rw_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one read/write
// channel to a server.  Exactly one transaction is in flight at a time:
// grant (IDLE) -> push command (CMD) -> pull server response (RSP) ->
// return response to the granted requester (RET).
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where
// both are high.  A valid, once raised, holds its payload stable until that
// edge.  A ready may be raised without a valid; it moves nothing by itself.
//
// cmd_data layout, MSB first: {wdata[DATA_WIDTH], addr zero-extended to 64,
// op zero-extended to DATA_WIDTH}.  With the default 64-bit data this is
// {wdata, addr64, op64}.  ADDR_WIDTH is expected to be at most 64.
module multisim_rw_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 64,
    parameter  int DATA_WIDTH = 64,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CMDW       = 2*DATA_WIDTH + 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // requester side
    input  logic [NUM_REQ-1:0]             req_vld,
    output logic [NUM_REQ-1:0]             req_rdy,
    input  logic [NUM_REQ-1:0]             req_op,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_vld,
    input  logic [NUM_REQ-1:0]             rsp_rdy,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    // server command push
    output logic                           cmd_vld,
    input  logic                           cmd_rdy,
    output logic [CMDW-1:0]                cmd_data,
    // server response pull
    input  logic                           srv_rsp_vld,
    output logic                           srv_rsp_rdy,
    input  logic [DATA_WIDTH-1:0]          srv_rsp_data,
    // status
    output logic [IDW-1:0]                 grant_id,
    output logic                           busy,
    output logic [31:0]                    txn_cnt,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2,
        RET  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [IDW-1:0]         last_grant;
    logic                   lat_op;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [DATA_WIDTH-1:0]  lat_rdata;

    logic                   rr_found;
    logic [IDW-1:0]         rr_idx;
    logic [IDW:0]           rr_cand;

    logic                   sel_op;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    logic                   grant_fire;
    logic                   rsp_fire;

    logic [63:0]            addr_ext;
    logic [DATA_WIDTH-1:0]  op_ext;

    // Round-robin search: first valid requester after last_grant, wrapping.
    // Offset NUM_REQ lands back on last_grant so a lone requester is re-granted.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = {1'b0, last_grant} + (IDW+1)'(k);
            if (rr_cand >= (IDW+1)'(NUM_REQ)) begin
                rr_cand = rr_cand - (IDW+1)'(NUM_REQ);
            end
            if (!rr_found && req_vld[rr_cand[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand[IDW-1:0];
            end
        end
    end

    // Select the winning requester's command fields.
    always_comb begin
        sel_op    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_idx == IDW'(i)) begin
                sel_op    = req_op[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and handshake outputs.  req_rdy is gated by rst_n so that no
    // grant is signalled while reset is held.
    always_comb begin
        state_nxt   = state;
        req_rdy     = '0;
        cmd_vld     = 1'b0;
        srv_rsp_rdy = 1'b0;
        rsp_vld     = '0;
        rsp_data    = '0;
        grant_fire  = 1'b0;
        rsp_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found && rst_n) begin
                    req_rdy[rr_idx] = 1'b1;
                    grant_fire      = 1'b1;
                    state_nxt       = CMD;
                end
            end
            CMD: begin
                cmd_vld = 1'b1;
                if (cmd_rdy) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                srv_rsp_rdy = 1'b1;
                if (srv_rsp_vld) begin
                    state_nxt = RET;
                end
            end
            RET: begin
                rsp_vld[grant_id] = 1'b1;
                rsp_data          = lat_rdata;
                if (rsp_rdy[grant_id]) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping and command capture; read commands carry zero wdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDW'(NUM_REQ - 1);
            grant_id   <= '0;
            lat_op     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (grant_fire) begin
            last_grant <= rr_idx;
            grant_id   <= rr_idx;
            lat_op     <= sel_op;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_op ? '0 : sel_wdata;
        end
    end

    // Capture the server response; writes also get one and it passes unmodified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rdata <= '0;
        end else if (state == RSP && srv_rsp_vld) begin
            lat_rdata <= srv_rsp_data;
        end
    end

    // Completed-transaction counter, free to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt <= '0;
        end else if (rsp_fire) begin
            txn_cnt <= txn_cnt + 32'd1;
        end
    end

    // Pack the command word from the latched fields.
    always_comb begin
        addr_ext                 = '0;
        addr_ext[ADDR_WIDTH-1:0] = lat_addr;
        op_ext                   = '0;
        op_ext[0]                = lat_op;
    end

    assign cmd_data  = {lat_wdata, addr_ext, op_ext};
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Structural promises made to neighbours.
    a_req_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_rdy));
    a_rsp_vld_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_vld));
    a_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_vld && !cmd_rdy) |=> (cmd_vld && $stable(cmd_data)));

endmodule

// File: tb/tb_multisim_rw_arbiter.sv
// Bench for multisim_rw_arbiter: directed transactions with hand-computed
// grants, command words and responses.
module tb_multisim_rw_arbiter;

    localparam int NR = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int CW = 2*DW + 64;

    // clock / reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT connections
    logic [NR-1:0]    req_vld;
    logic [NR-1:0]    req_rdy;
    logic [NR-1:0]    req_op;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    rsp_vld;
    logic [NR-1:0]    rsp_rdy;
    logic [DW-1:0]    rsp_data;
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [CW-1:0]    cmd_data;
    logic             srv_rsp_vld;
    logic             srv_rsp_rdy;
    logic [DW-1:0]    srv_rsp_data;
    logic [1:0]       grant_id;
    logic             busy;
    logic [31:0]      txn_cnt;
    logic [1:0]       dbg_state;

    multisim_rw_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_vld      (rsp_vld),
        .rsp_rdy      (rsp_rdy),
        .rsp_data     (rsp_data),
        .cmd_vld      (cmd_vld),
        .cmd_rdy      (cmd_rdy),
        .cmd_data     (cmd_data),
        .srv_rsp_vld  (srv_rsp_vld),
        .srv_rsp_rdy  (srv_rsp_rdy),
        .srv_rsp_data (srv_rsp_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .txn_cnt      (txn_cnt),
        .dbg_state    (dbg_state)
    );

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]      exp_gnt_q[$];
    logic [CW-1:0]   exp_cmd_q[$];
    logic [NR+DW-1:0] exp_rsp_q[$];

    logic [1:0]       mon_gnt;
    logic [CW-1:0]    mon_cmd;
    logic [NR+DW-1:0] mon_rsp;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops an expectation whenever the DUT presents a grant,
    // a command transfer or a response transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_rdy != '0) begin
                if (exp_gnt_q.size() == 0) begin
                    check("unexpected_grant", 256'(req_rdy), 256'(0));
                end else begin
                    mon_gnt = exp_gnt_q.pop_front();
                    check("grant", 256'(req_rdy), 256'(4'b0001 << mon_gnt));
                end
            end
            if (cmd_vld && cmd_rdy) begin
                if (exp_cmd_q.size() == 0) begin
                    check("unexpected_cmd", 256'(cmd_data), 256'(0));
                end else begin
                    mon_cmd = exp_cmd_q.pop_front();
                    check("cmd_data", 256'(cmd_data), 256'(mon_cmd));
                end
            end
            if ((rsp_vld & rsp_rdy) != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    check("unexpected_rsp", 256'({rsp_vld, rsp_data}), 256'(0));
                end else begin
                    mon_rsp = exp_rsp_q.pop_front();
                    check("rsp", 256'({rsp_vld, rsp_data}), 256'(mon_rsp));
                end
            end
        end
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int id, input logic op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        req_op[id]               = op;
        req_addr[id*AW +: AW]    = addr;
        req_wdata[id*DW +: DW]   = wdata;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_rdy"},     256'(req_rdy),     256'(0));
        check({tag, "_rsp_vld"},     256'(rsp_vld),     256'(0));
        check({tag, "_rsp_data"},    256'(rsp_data),    256'(0));
        check({tag, "_cmd_vld"},     256'(cmd_vld),     256'(0));
        check({tag, "_cmd_data"},    256'(cmd_data),    256'(0));
        check({tag, "_srv_rsp_rdy"}, 256'(srv_rsp_rdy), 256'(0));
        check({tag, "_grant_id"},    256'(grant_id),    256'(0));
        check({tag, "_busy"},        256'(busy),        256'(0));
        check({tag, "_txn_cnt"},     256'(txn_cnt),     256'(0));
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        rst_n        = 1'b0;
        req_vld      = '0;
        req_op       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_rdy      = '0;
        cmd_rdy      = 1'b0;
        srv_rsp_vld  = 1'b0;
        srv_rsp_data = '0;

        // reset state, with requests pending to show req_rdy stays low
        repeat (2) @(posedge clk);
        #1;
        req_vld = 4'b1111;
        smp();
        check_all_zero("reset");
        tick();
        req_vld = '0;
        rst_n   = 1'b1;

        // single write from requester 1, all readies high
        tick();
        cmd_rdy      = 1'b1;
        srv_rsp_vld  = 1'b1;
        srv_rsp_data = 64'h0000_0000_0000_00a5;
        rsp_rdy      = 4'b1111;
        set_req(1, 1'b0, 64'h5, 64'hdeadbeefcafedeca);
        req_vld      = 4'b0010;
        exp_gnt_q.push_back(2'd1);
        exp_cmd_q.push_back({64'hdeadbeefcafedeca, 64'h5, 64'h0});
        exp_rsp_q.push_back({4'b0010, 64'h0000_0000_0000_00a5});
        smp();                                   // cycle 0: grant
        tick();
        req_vld = '0;
        smp();                                   // cycle 1
        check("wr_c1_cmd_vld", 256'(cmd_vld), 256'(1));
        check("wr_c1_busy", 256'(busy), 256'(1));
        tick(); smp();                           // cycle 2
        check("wr_c2_srv_rsp_rdy", 256'(srv_rsp_rdy), 256'(1));
        tick(); smp();                           // cycle 3
        check("wr_c3_rsp_vld", 256'(rsp_vld), 256'(4'b0010));
        tick(); smp();                           // cycle 4
        check("wr_txn_cnt", 256'(txn_cnt), 256'(1));
        check("wr_idle", 256'(busy), 256'(0));

        // single read from requester 2; its wdata must not reach the command
        tick();
        srv_rsp_data = 64'hbebecacadeadb00e;
        set_req(2, 1'b1, 64'h3, 64'hffff_ffff_ffff_ffff);
        req_vld      = 4'b0100;
        exp_gnt_q.push_back(2'd2);
        exp_cmd_q.push_back({64'h0, 64'h3, 64'h1});
        exp_rsp_q.push_back({4'b0100, 64'hbebecacadeadb00e});
        smp();
        tick();
        req_vld = '0;
        smp();
        repeat (3) begin
            tick(); smp();
        end
        check("rd_txn_cnt", 256'(txn_cnt), 256'(2));
        check("rd_idle_rsp_data", 256'(rsp_data), 256'(0));
        check("rd_idle_rsp_vld", 256'(rsp_vld), 256'(0));

        // all four requesters valid straight out of reset
        tick();
        rst_n        = 1'b0;
        srv_rsp_data = 64'h77;
        req_op       = '0;
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b0, 64'h10 + 64'(i), 64'h1000 + 64'(i));
        end
        smp();
        tick();
        rst_n   = 1'b1;
        req_vld = 4'b1111;
        exp_gnt_q.push_back(2'd0);
        exp_gnt_q.push_back(2'd1);
        exp_gnt_q.push_back(2'd2);
        exp_gnt_q.push_back(2'd3);
        exp_gnt_q.push_back(2'd0);
        exp_cmd_q.push_back({64'h1000, 64'h10, 64'h0});
        exp_cmd_q.push_back({64'h1001, 64'h11, 64'h0});
        exp_cmd_q.push_back({64'h1002, 64'h12, 64'h0});
        exp_cmd_q.push_back({64'h1003, 64'h13, 64'h0});
        exp_cmd_q.push_back({64'h1000, 64'h10, 64'h0});
        exp_rsp_q.push_back({4'b0001, 64'h77});
        exp_rsp_q.push_back({4'b0010, 64'h77});
        exp_rsp_q.push_back({4'b0100, 64'h77});
        exp_rsp_q.push_back({4'b1000, 64'h77});
        exp_rsp_q.push_back({4'b0001, 64'h77});
        smp();                                   // cycle 0
        repeat (16) begin
            tick(); smp();
        end                                      // cycle 16
        check("rr_txn_cnt_c16", 256'(txn_cnt), 256'(4));
        repeat (3) begin
            tick(); smp();
        end                                      // cycle 19
        tick();
        req_vld = '0;
        smp();                                   // cycle 20
        check("rr_txn_cnt_c20", 256'(txn_cnt), 256'(5));
        check("rr_grant_id", 256'(grant_id), 256'(0));
        check("rr_idle", 256'(busy), 256'(0));

        // backpressure on every stage; requester 0 keeps req_vld high
        tick();
        cmd_rdy      = 1'b0;
        srv_rsp_vld  = 1'b0;
        rsp_rdy      = '0;
        srv_rsp_data = 64'h5a5a5a5a5a5a5a5a;
        set_req(0, 1'b0, 64'h40, 64'h0123456789abcdef);
        req_vld      = 4'b0001;
        exp_gnt_q.push_back(2'd0);
        exp_cmd_q.push_back({64'h0123456789abcdef, 64'h40, 64'h0});
        exp_rsp_q.push_back({4'b0001, 64'h5a5a5a5a5a5a5a5a});
        smp();                                   // cycle 0
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 2) begin
                req_wdata[0 +: DW] = 64'hffff_0000_ffff_0000;
            end
            smp();
            check("bp_cmd_vld", 256'(cmd_vld), 256'(1));
            check("bp_cmd_stable", 256'(cmd_data),
                  256'({64'h0123456789abcdef, 64'h40, 64'h0}));
            check("bp_no_req_rdy", 256'(req_rdy), 256'(0));
        end
        tick();
        cmd_rdy = 1'b1;
        smp();                                   // cycle 6: command accepted
        tick();
        cmd_rdy = 1'b0;
        smp();
        for (int i = 0; i < 3; i++) begin        // cycles 7..9: server late
            if (i > 0) begin
                tick(); smp();
            end
            check("bp_srv_rsp_rdy", 256'(srv_rsp_rdy), 256'(1));
            check("bp_no_rsp_yet", 256'(rsp_vld), 256'(0));
        end
        tick();
        srv_rsp_vld = 1'b1;
        smp();                                   // cycle 10
        tick();
        srv_rsp_vld = 1'b0;
        smp();                                   // cycle 11
        check("bp_rsp_vld_c11", 256'(rsp_vld), 256'(4'b0001));
        check("bp_rsp_data_c11", 256'(rsp_data), 256'(64'h5a5a5a5a5a5a5a5a));
        tick(); smp();                           // cycle 12
        check("bp_rsp_vld_c12", 256'(rsp_vld), 256'(4'b0001));
        tick();
        rsp_rdy = 4'b0001;
        req_vld = '0;
        smp();                                   // cycle 13: response taken
        tick();
        rsp_rdy = '0;
        smp();                                   // cycle 14
        check("bp_txn_cnt", 256'(txn_cnt), 256'(6));
        check("bp_rsp_vld_done", 256'(rsp_vld), 256'(0));
        check("bp_rsp_data_zero", 256'(rsp_data), 256'(0));

        // ready from the wrong requester must not complete RET
        tick();
        cmd_rdy      = 1'b1;
        srv_rsp_vld  = 1'b1;
        srv_rsp_data = 64'h3333_3333_3333_3333;
        rsp_rdy      = 4'b0001;
        set_req(3, 1'b1, 64'h33, 64'habc);
        req_vld      = 4'b1000;
        exp_gnt_q.push_back(2'd3);
        exp_cmd_q.push_back({64'h0, 64'h33, 64'h1});
        exp_rsp_q.push_back({4'b1000, 64'h3333_3333_3333_3333});
        smp();                                   // cycle 0
        tick();
        req_vld = '0;
        smp();
        tick(); smp();                           // cycle 2
        for (int i = 0; i < 3; i++) begin        // cycles 3..5
            tick(); smp();
            check("wr_rdy_rsp_vld", 256'(rsp_vld), 256'(4'b1000));
            check("wr_rdy_state", 256'(dbg_state), 256'(2'd3));
        end
        tick();
        rsp_rdy = 4'b1000;
        smp();                                   // cycle 6
        tick();
        rsp_rdy = '0;
        smp();
        check("wr_rdy_txn_cnt", 256'(txn_cnt), 256'(7));
        check("wr_rdy_idle", 256'(busy), 256'(0));

        // reset in the middle of RSP
        tick();
        cmd_rdy      = 1'b1;
        srv_rsp_vld  = 1'b0;
        rsp_rdy      = 4'b1111;
        set_req(1, 1'b0, 64'h99, 64'h1234);
        req_vld      = 4'b0010;
        exp_gnt_q.push_back(2'd1);
        exp_cmd_q.push_back({64'h1234, 64'h99, 64'h0});
        smp();                                   // cycle 0
        tick();
        req_vld = 4'b0011;
        smp();                                   // cycle 1: command taken
        tick(); smp();                           // cycle 2: RSP
        check("rst_pre_srv_rsp_rdy", 256'(srv_rsp_rdy), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        rst_n        = 1'b1;
        srv_rsp_vld  = 1'b1;
        srv_rsp_data = 64'h600d;
        set_req(0, 1'b0, 64'h60, 64'h6000);
        exp_gnt_q.push_back(2'd0);
        exp_cmd_q.push_back({64'h6000, 64'h60, 64'h0});
        exp_rsp_q.push_back({4'b0001, 64'h600d});
        smp();                                   // cycle 0: grant to 0
        check("rst_txn_cnt_zero", 256'(txn_cnt), 256'(0));
        tick();
        req_vld = '0;
        smp();
        repeat (3) begin
            tick(); smp();
        end
        check("rst_post_txn_cnt", 256'(txn_cnt), 256'(1));

        // every expectation consumed
        tick(); smp();
        check("gnt_q_empty", 256'(exp_gnt_q.size()), 256'(0));
        check("cmd_q_empty", 256'(exp_cmd_q.size()), 256'(0));
        check("rsp_q_empty", 256'(exp_rsp_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
